// File: rtl/karatsuba_mult_scheduler.sv
// Sequencer for karatsuba_poly_mult_preprocessor: serial operand load, wait for the fixed
// multiplier latency, then serial product drain. Optional KPM_SCHED_PERF_EN adds job/stall counters.
//
// state | meaning
// IDLE  | single cycle after reset release
// LOAD  | accepting 2N operand words (A coefficients, then B coefficients)
// RUN   | multiplier in flight, counting down LAT cycles
// DRAIN | streaming 2N-1 product coefficients
module karatsuba_mult_scheduler #(
    parameter int N   = 8,
    parameter int D   = 16,
    parameter int PW  = 35,
    parameter int LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [D-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [D*N-1:0]           mult_a,
    output logic [D*N-1:0]           mult_b,
    output logic                     mult_start,
    input  logic [PW*(2*N-1)-1:0]    mult_p,
    output logic [PW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
`ifdef KPM_SCHED_PERF_EN
    ,
    output logic [15:0]              perf_jobs,
    output logic [15:0]              perf_stall
`endif
);

    localparam int NP = 2*N - 1;
    localparam int IW = $clog2(2*N);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  load_idx, load_idx_nxt;
    logic [IW-1:0]  drain_idx, drain_idx_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           latch_p;
    logic           wr_en;

    logic [D-1:0]   op_a [N];
    logic [D-1:0]   op_b [N];
    logic [PW-1:0]  prod [NP];

    always_comb begin
        state_nxt     = state;
        load_idx_nxt  = load_idx;
        drain_idx_nxt = drain_idx;
        cnt_nxt       = cnt;
        latch_p       = 1'b0;
        wr_en         = 1'b0;
        if (clear) begin
            state_nxt     = LOAD;
            load_idx_nxt  = '0;
            drain_idx_nxt = '0;
            cnt_nxt       = '0;
        end else begin
            case (state)
                IDLE: state_nxt = LOAD;
                LOAD: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        if (load_idx == IW'(2*N-1)) begin
                            state_nxt    = RUN;
                            load_idx_nxt = '0;
                            cnt_nxt      = CW'(LAT);
                        end else begin
                            load_idx_nxt = load_idx + IW'(1);
                        end
                    end
                end
                RUN: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        latch_p       = 1'b1;
                        state_nxt     = DRAIN;
                        drain_idx_nxt = '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (drain_idx == IW'(NP-1)) begin
                            state_nxt     = LOAD;
                            drain_idx_nxt = '0;
                        end else begin
                            drain_idx_nxt = drain_idx + IW'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            load_idx  <= '0;
            drain_idx <= '0;
            cnt       <= '0;
            for (int i = 0; i < N; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
            end
            for (int k = 0; k < NP; k++) prod[k] <= '0;
        end else begin
            state     <= state_nxt;
            load_idx  <= load_idx_nxt;
            drain_idx <= drain_idx_nxt;
            cnt       <= cnt_nxt;
            // top index bit selects A (first N words) or B (second N words)
            if (wr_en) begin
                if (load_idx[IW-1]) op_b[load_idx[IW-2:0]] <= in_data;
                else                op_a[load_idx[IW-2:0]] <= in_data;
            end
            if (latch_p) begin
                for (int k = 0; k < NP; k++) prod[k] <= mult_p[PW*k +: PW];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mult_a[D*i +: D] = op_a[i];
            mult_b[D*i +: D] = op_b[i];
        end
    end

    assign in_ready   = (state == LOAD);
    assign busy       = (state == RUN) || (state == DRAIN);
    assign mult_start = (state == RUN) && (cnt == CW'(LAT));
    assign out_valid  = (state == DRAIN);
    assign out_last   = (state == DRAIN) && (drain_idx == IW'(NP-1));
    assign out_data   = (state == DRAIN) ? prod[drain_idx] : '0;

`ifdef KPM_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (out_last && out_ready) perf_jobs <= perf_jobs + 16'd1;
            if (out_valid && !out_ready && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_karatsuba_mult_scheduler.sv
// Self-checking bench for karatsuba_mult_scheduler: a job-level reference model checked every
// cycle, a latency-accurate reference multiplier on mult_p, and literal expectations per scenario.
module tb_karatsuba_mult_scheduler;

    localparam int N   = 8;
    localparam int D   = 16;
    localparam int PW  = 35;
    localparam int LAT = 4;
    localparam int NP  = 2*N - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  clear = 1'b0;
    logic [D-1:0]          in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [D*N-1:0]        mult_a, mult_b;
    logic                  mult_start;
    logic [PW*NP-1:0]      mult_p;
    logic [PW-1:0]         out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic                  out_last;
    logic                  busy;
`ifdef KPM_SCHED_PERF_EN
    logic [15:0]           perf_jobs, perf_stall;
`endif

    karatsuba_mult_scheduler #(.N(N), .D(D), .PW(PW), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start), .mult_p(mult_p),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
`ifdef KPM_SCHED_PERF_EN
        , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s timeout at %0t", nm, $time);
    endtask

    // Reference multiplier: result valid only in cycle S+LAT-1, all-ones garbage otherwise.
    function automatic logic [PW*NP-1:0] pmul(input logic [D*N-1:0] a, input logic [D*N-1:0] b);
        logic [PW*NP-1:0] r;
        logic [PW-1:0]    acc;
        r = '0;
        for (int k = 0; k < NP; k++) begin
            acc = '0;
            for (int i = 0; i < N; i++) begin
                if (k - i >= 0 && k - i < N)
                    acc = acc + PW'(a[D*i +: D]) * PW'(b[D*(k-i) +: D]);
            end
            r[PW*k +: PW] = acc;
        end
        return r;
    endfunction

    int tcyc, start_t;
    bit started;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcyc <= 0; start_t <= 0; started <= 1'b0;
        end else begin
            tcyc <= tcyc + 1;
            if (mult_start) begin
                started <= 1'b1;
                start_t <= tcyc;
            end
        end
    end
    always_comb begin
        mult_p = '1;
        if (started && tcyc == start_t + LAT - 1) mult_p = pmul(mult_a, mult_b);
    end

    // Job-level model
    logic [D-1:0]   words [$];
    logic [PW-1:0]  exp_q [$];
    logic [PW-1:0]  got   [$];
    bit             job_pending;
    int             cyc, acc_cyc, since_rst, n_start;
    bit             prev_stall;
    logic [PW-1:0]  prev_data;
`ifdef KPM_SCHED_PERF_EN
    int             stall_m, jobs_m;
`endif

    function automatic logic [D*N-1:0] pack_words(input int off);
        logic [D*N-1:0] r;
        for (int i = 0; i < N; i++) r[D*i +: D] = words[off + i];
        return r;
    endfunction

    function automatic logic [PW-1:0] model_coef(input int k);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i + j == k) s = s + 64'(words[i]) * 64'(words[N + j]);
        return PW'(s);
    endfunction

    always @(negedge clk) begin
        bit e_ir, e_st, e_ov;
        if (!rst_n) begin
            chk("rst_ctrl", {in_ready, mult_start, out_valid, out_last, busy}, 5'b0);
            chk("rst_out_data", out_data, 0);
            chk("rst_mult_ab", {mult_a, mult_b}, 0);
            words.delete(); exp_q.delete();
            job_pending = 0; since_rst = 0; cyc = 0; prev_stall = 0;
`ifdef KPM_SCHED_PERF_EN
            stall_m = 0; jobs_m = 0;
`endif
        end else begin
            e_ir = (since_rst >= 1) && !job_pending;
            e_st = job_pending && (cyc == acc_cyc + 1);
            e_ov = job_pending && (cyc >= acc_cyc + 1 + LAT);
            chk("in_ready", in_ready, e_ir);
            chk("busy", busy, job_pending);
            chk("mult_start", mult_start, e_st);
            chk("out_valid", out_valid, e_ov);
            if (mult_start) n_start++;
            if (e_ov) begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", out_last, exp_q.size() == 1);
                if (prev_stall) chk("stall_hold", out_data, prev_data);
            end else begin
                chk("out_last_idle", out_last, 0);
            end
            if (job_pending) begin
                chk("mult_a", mult_a, pack_words(0));
                chk("mult_b", mult_b, pack_words(N));
            end
            prev_stall = e_ov && !out_ready;
            prev_data  = out_data;
`ifdef KPM_SCHED_PERF_EN
            if (e_ov && !out_ready) stall_m++;
            if (e_ov && out_ready && exp_q.size() == 1) jobs_m++;
`endif
            if (clear) begin
                words.delete(); exp_q.delete(); job_pending = 0; prev_stall = 0;
            end else begin
                if (e_ir && in_valid) begin
                    words.push_back(in_data);
                    if (words.size() == 2*N) begin
                        for (int k = 0; k < NP; k++) exp_q.push_back(model_coef(k));
                        job_pending = 1;
                        acc_cyc = cyc;
                    end
                end
                if (e_ov && out_ready) begin
                    got.push_back(out_data);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        job_pending = 0;
                        words.delete();
                    end
                end
            end
            cyc++;
            if (since_rst < 1000) since_rst++;
        end
    end

    // Stimulus tasks; all begin and end aligned just after a rising edge.
    task automatic send(input logic [D-1:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) timeout("send");
    endtask

    task automatic load_job(input logic [D-1:0] ba, input logic [D-1:0] sa,
                            input logic [D-1:0] bb, input logic [D-1:0] sb, input int gap);
        for (int i = 0; i < 2*N; i++) begin
            if (i < N) send(D'(ba + sa * D'(i)));
            else       send(D'(bb + sb * D'(i - N)));
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain_job(input bit bp);
        logic [3:0] pat;
        bit done = 0;
        pat = 4'b1001;
        for (int i = 0; i < 400 && !done; i++) begin
            out_ready = bp ? pat[3 - (i % 4)] : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready && out_last) done = 1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (!done) timeout("drain");
    endtask

    initial begin
        logic [PW-1:0] exp1 [NP];
        logic [PW-1:0] exp_clr [NP];
        bit seen;
        exp1    = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};
        exp_clr = '{6, 12, 18, 24, 30, 36, 42, 48, 42, 36, 30, 24, 18, 12, 6};

        // reset held 3 cycles, in_ready exactly one cycle after release
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); chk("idle_in_ready", in_ready, 0);
        @(negedge clk); chk("load_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // all-ones job
        got.delete(); n_start = 0;
        load_job(16'h1, 16'h0, 16'h1, 16'h0, 0);
        drain_job(0);
        chk("ones_count", got.size(), NP);
        for (int k = 0; k < NP && k < got.size(); k++) chk("ones_word", got[k], exp1[k]);
        chk("ones_start_pulses", n_start, 1);

        // backpressure 1,0,0,1
        got.delete();
        load_job(16'hFFFF, 16'hFFFF, 16'h8001, 16'h0101, 0);
        drain_job(1);
        chk("bp_count", got.size(), NP);
`ifdef KPM_SCHED_PERF_EN
        chk("bp_perf_stall", perf_stall, stall_m);
        chk("bp_perf_jobs", perf_jobs, jobs_m);
`endif

        // clear after 5 words; the word offered with clear is dropped
        got.delete();
        for (int i = 0; i < 5; i++) send(16'h00A0 + D'(i));
        clear = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        load_job(16'h2, 16'h0, 16'h3, 16'h0, 0);
        drain_job(0);
        chk("clr_count", got.size(), NP);
        for (int k = 0; k < NP && k < got.size(); k++) chk("clr_word", got[k], exp_clr[k]);

        // sparse input, one word every third cycle
        got.delete();
        load_job(16'h0100, 16'h1, 16'h0200, 16'h1, 2);
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("sparse_mult_a", mult_a[D*i +: D], 16'h0100 + i);
        for (int i = 0; i < N; i++) chk("sparse_mult_b", mult_b[D*i +: D], 16'h0200 + i);
        @(posedge clk); #1;
        drain_job(0);
        chk("sparse_count", got.size(), NP);

        // reset during DRAIN while coefficient 4 is presented
        got.delete();
        out_ready = 1'b0;
        load_job(16'h3, 16'h1, 16'h5, 16'h2, 0);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) timeout("mid_drain_valid");
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        chk("mid_drain_presented", got.size(), 4);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        load_job(16'h1, 16'h1, 16'h1, 16'h0, 0);
        drain_job(0);
        chk("post_rst_count", got.size(), NP);
        if (got.size() == NP) begin
            chk("post_rst_first", got[0], 1);
            chk("post_rst_mid", got[N-1], 36);
            chk("post_rst_last", got[NP-1], 8);
        end
`ifdef KPM_SCHED_PERF_EN
        chk("post_rst_perf_jobs", perf_jobs, 1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
